snake_food_gen: RTL and testbench

- Food (apple) generator sitting directly upstream of the snake controller.
- Places food on a random interior grid cell and watches the snake head coordinates.
- On a hit, it drives the add_cube growth request into the snake controller and keeps a 2-digit BCD score.
- It also provides the food pixel flag for the VGA renderer.

---
 rtl/snake_pkg.sv | 50 +++++
 rtl/snake_lfsr16.sv | 26 ++
 rtl/snake_food_gen.sv | 132 +++++++++++++
 tb/tb_snake_food_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: status/display/direction codes, grid geometry,
// food FSM states and the saturating BCD score increment.
package snake_pkg;

  typedef enum logic [1:0] {
    GS_RESTART = 2'b00,
    GS_PLAY    = 2'b10,
    GS_DIE     = 2'b11
  } game_status_e;

  typedef enum logic [1:0] {
    DISP_NONE,
    DISP_HEAD,
    DISP_BODY,
    DISP_WALL
  } disp_e;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;
  localparam int unsigned CELL_SHIFT = 4;

  localparam logic [5:0] X_MIN = 6'd1;
  localparam logic [5:0] X_MAX = 6'd38;
  localparam logic [5:0] Y_MIN = 6'd1;
  localparam logic [5:0] Y_MAX = 6'd28;

  typedef enum logic [1:0] {
    FOOD_IDLE,
    FOOD_PLACE,
    FOOD_ACTIVE,
    FOOD_EAT
  } food_state_e;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick food cells.
module snake_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_state = r_lfsr;

  // The all-zero lock-up state is escaped by forcing a non-zero value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lfsr <= SEED;
    else if (r_lfsr == '0)
      r_lfsr <= 16'h0001;
    else
      r_lfsr <= {r_lfsr[14:0], w_fb};
  end

endmodule

// File: rtl/snake_food_gen.sv
// Food generator: random interior placement, head-hit detection, growth pulse and BCD score.
// Optional FOOD_TIMEOUT_EN relocates uneaten food after TIMEOUT_CYC active play cycles.
module snake_food_gen
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned ADD_PULSE_CYC = 4,
  parameter logic [31:0] TIMEOUT_CYC   = 32'd250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] game_status,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic       add_cube,
  output logic       food_valid,
  output logic [5:0] food_x,
  output logic [5:0] food_y,
  output logic       food_show,
  output logic [7:0] score
);

  logic [15:0] w_lfsr;
  logic [5:0]  w_cx;
  logic [5:0]  w_cy;
  logic        w_cand_ok;
  logic        w_head_hit;
  logic        w_unused;

  food_state_e r_state;
  logic [3:0]  r_pulse_cnt;
  logic        r_add_cube;
  logic        r_food_valid;
  logic [5:0]  r_food_x;
  logic [5:0]  r_food_y;
  logic [7:0]  r_score;
`ifdef FOOD_TIMEOUT_EN
  logic [31:0] r_tmo;
`endif

  snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_state (w_lfsr)
  );

  assign w_cx       = w_lfsr[5:0];
  assign w_cy       = {1'b0, w_lfsr[12:8]};
  assign w_cand_ok  = (w_cx >= X_MIN) && (w_cx <= X_MAX) &&
                      (w_cy >= Y_MIN) && (w_cy <= Y_MAX) &&
                      !((w_cx == head_x) && (w_cy == head_y));
  assign w_head_hit = (head_x == r_food_x) && (head_y == r_food_y);
  assign w_unused   = ^{TIMEOUT_CYC, w_lfsr[15:13], w_lfsr[7:6], pos_x[3:0], pos_y[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FOOD_IDLE;
      r_pulse_cnt  <= '0;
      r_add_cube   <= 1'b0;
      r_food_valid <= 1'b0;
      r_food_x     <= '0;
      r_food_y     <= '0;
      r_score      <= '0;
`ifdef FOOD_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else if (game_status == GS_RESTART) begin
      r_state      <= FOOD_IDLE;
      r_pulse_cnt  <= '0;
      r_add_cube   <= 1'b0;
      r_food_valid <= 1'b0;
      r_score      <= '0;
    end else if (game_status == GS_PLAY) begin
      case (r_state)
        FOOD_IDLE: r_state <= FOOD_PLACE;
        FOOD_PLACE: begin
          if (w_cand_ok) begin
            r_food_x     <= w_cx;
            r_food_y     <= w_cy;
            r_food_valid <= 1'b1;
            r_state      <= FOOD_ACTIVE;
`ifdef FOOD_TIMEOUT_EN
            r_tmo        <= '0;
`endif
          end
        end
        FOOD_ACTIVE: begin
          if (w_head_hit) begin
            r_add_cube   <= 1'b1;
            r_pulse_cnt  <= 4'd1;
            r_food_valid <= 1'b0;
            r_score      <= bcd_inc_sat(r_score);
            r_state      <= FOOD_EAT;
          end
`ifdef FOOD_TIMEOUT_EN
          else if (r_tmo == TIMEOUT_CYC - 32'd1) begin
            r_food_valid <= 1'b0;
            r_state      <= FOOD_PLACE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
`endif
        end
        // Counter holds the number of high cycles already issued, so a pulse
        // cut short by DIE re-asserts for only the remainder on resume.
        FOOD_EAT: begin
          if (r_pulse_cnt >= 4'(ADD_PULSE_CYC)) begin
            r_add_cube  <= 1'b0;
            r_pulse_cnt <= '0;
            r_state     <= FOOD_PLACE;
          end else begin
            r_add_cube  <= 1'b1;
            r_pulse_cnt <= r_pulse_cnt + 4'd1;
          end
        end
        default: r_state <= FOOD_IDLE;
      endcase
    end else begin
      r_add_cube <= 1'b0;
    end
  end

  assign add_cube   = r_add_cube;
  assign food_valid = r_food_valid;
  assign food_x     = r_food_x;
  assign food_y     = r_food_y;
  assign score      = r_score;
  assign food_show  = r_food_valid && (pos_x[9:4] == r_food_x) && (pos_y[9:4] == r_food_y);

endmodule

// File: tb/tb_snake_food_gen.sv
// Directed self-checking bench for snake_food_gen with an independent LFSR placement model.
`timescale 1ns/1ps
module tb_snake_food_gen;

  localparam logic [15:0] SEED = 16'hACE1;
`ifdef FOOD_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'd100;
`else
  localparam logic [31:0] TMO = 32'd250_000_000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] game_status;
  logic [5:0] head_x, head_y;
  logic [9:0] pos_x, pos_y;
  logic       add_cube, food_valid, food_show;
  logic [5:0] food_x, food_y;
  logic [7:0] score;

  int         n_total = 0;
  int         n_bad = 0;
  logic [15:0] m_lfsr;
  logic [5:0] exp_fx, exp_fy;

  snake_food_gen #(
    .LFSR_SEED     (SEED),
    .ADD_PULSE_CYC (4),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_status (game_status),
    .head_x      (head_x),
    .head_y      (head_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .add_cube    (add_cube),
    .food_valid  (food_valid),
    .food_x      (food_x),
    .food_y      (food_y),
    .food_show   (food_show),
    .score       (score)
  );

  always #20 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [7:0] bcd_of(input int n);
    int e;
    e = (n > 99) ? 99 : n;
    return {4'(e / 10), 4'(e % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First acceptable candidate starting from LFSR value v; n = rejected tries.
  task automatic predict(input logic [15:0] v, output logic [5:0] fx, output logic [5:0] fy,
                         output int n);
    logic [5:0] cx, cy;
    bit found;
    found = 0; n = 0; fx = '0; fy = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      cx = v[5:0];
      cy = {1'b0, v[12:8]};
      if (cx >= 6'd1 && cx <= 6'd38 && cy >= 6'd1 && cy <= 6'd28 &&
          !(cx == head_x && cy == head_y)) begin
        found = 1; fx = cx; fy = cy;
      end else begin
        v = lfsr_next(v);
        n++;
      end
    end
  endtask

  // Called at a negedge whose following posedge is the first PLACE evaluation.
  task automatic wait_place(input string tag);
    logic [5:0] fx, fy;
    int n;
    bit seen;
    seen = 0;
    predict(m_lfsr, fx, fy, n);
    for (int k = 1; k <= 64 && !seen; k++) begin
      @(negedge clk);
      if (food_valid) begin
        seen = 1;
        chk({tag, "_lat"}, k, n + 1);
        chk({tag, "_fx"}, food_x, fx);
        chk({tag, "_fy"}, food_y, fy);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    exp_fx = fx;
    exp_fy = fy;
  endtask

  // Called at a negedge in ACTIVE; steers the head onto the expected food.
  task automatic eat(input string tag, input logic [7:0] exp_score, input bit restart_mid,
                     input bit full);
    head_x = exp_fx;
    head_y = exp_fy;
    @(negedge clk);
    chk({tag, "_add1"}, add_cube, 1);
    chk({tag, "_score"}, score, exp_score);
    if (full) chk({tag, "_valid0"}, food_valid, 0);
    if (restart_mid) begin
      @(negedge clk);
      chk({tag, "_add2"}, add_cube, 1);
      game_status = 2'b00;
      @(negedge clk);
      chk({tag, "_rs_add"}, add_cube, 0);
      chk({tag, "_rs_score"}, score, 8'h00);
      chk({tag, "_rs_valid"}, food_valid, 0);
      chk({tag, "_rs_show"}, food_show, 0);
    end else begin
      for (int c = 2; c <= 4; c++) begin
        @(negedge clk);
        if (full) chk({tag, "_addhi"}, add_cube, 1);
      end
      @(negedge clk);
      chk({tag, "_addlo"}, add_cube, 0);
      wait_place({tag, "_place"});
    end
  endtask

  initial begin
    game_status = 2'b00;
    head_x = 6'd10;
    head_y = 6'd5;
    pos_x = '0;
    pos_y = '0;
    #5 rst_n = 1'b0;
    #1;
    chk("rst_add", add_cube, 0);
    chk("rst_valid", food_valid, 0);
    chk("rst_fx", food_x, 0);
    chk("rst_fy", food_y, 0);
    chk("rst_score", score, 8'h00);
    chk("rst_show", food_show, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    game_status = 2'b10;
    @(negedge clk);
    wait_place("first");
    chk("first_xrange", (food_x >= 6'd1 && food_x <= 6'd38), 1);
    chk("first_yrange", (food_y >= 6'd1 && food_y <= 6'd28), 1);
    chk("first_not_head", (food_x == 6'd10 && food_y == 6'd5), 0);

    for (int i = 1; i <= 99; i++)
      eat("eat", bcd_of(i), 1'b0, i == 1 || i == 10 || i == 99);
    eat("sat", 8'h99, 1'b0, 1'b1);

    pos_x = {exp_fx, 4'd7};
    pos_y = {exp_fy, 4'd7};
    #1 chk("show_mid", food_show, 1);
    pos_x = {exp_fx, 4'hF};
    #1 chk("show_right_edge", food_show, 1);
    pos_x = {exp_fx, 4'd0} + 10'd16;
    #1 chk("show_next_col", food_show, 0);
    pos_x = {exp_fx, 4'd0};
    pos_y = {exp_fy, 4'd0} + 10'd16;
    #1 chk("show_next_row", food_show, 0);

`ifdef FOOD_TIMEOUT_EN
    @(negedge clk);
    repeat (98) @(negedge clk);
    chk("tmo_hold", food_valid, 1);
    @(negedge clk);
    chk("tmo_drop", food_valid, 0);
    chk("tmo_score", score, 8'h99);
    chk("tmo_add", add_cube, 0);
    wait_place("tmo_place");
`endif

    pos_x = {exp_fx, 4'd3};
    pos_y = {exp_fy, 4'd3};
    #1 chk("show_pre_restart", food_show, 1);
    eat("rst_eat", 8'h99, 1'b1, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("idle_hold", food_valid, 0);
    end
    game_status = 2'b10;
    @(negedge clk);
    wait_place("replay");
    chk("replay_score", score, 8'h00);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_add", add_cube, 0);
    chk("mid_rst_valid", food_valid, 0);
    chk("mid_rst_score", score, 8'h00);
    chk("mid_rst_fx", food_x, 0);
    chk("mid_rst_fy", food_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
